// File: rtl/m_unit_pkg.sv
// m_unit_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   - FSM state encoding (IDLE, MUL, DIV, DONE)
//   - func3 encodings of the M-extension operations
//   - DIV_ITER: number of restoring shift-subtract iterations
//   - small helpers to classify func3
package m_unit_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int DIV_ITER = 32;

  // func3 1xx selects the divide/remainder family.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM (even func3 within the divide family) are signed.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/m_div_core.sv
// m_div_core: radix-2 restoring divider datapath for the M unit.
// The sequencer FSM owns the iteration count; this block only holds the
// partial remainder / quotient and performs one shift-subtract per step.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture operand magnitudes and result signs
//   step                perform one shift-subtract iteration
//   fix                 apply the sign fix-up to the outputs
//   is_signed           operands are two's complement (DIV/REM)
//   dividend, divisor   raw operands, sampled on load
//   quotient, remainder unsigned results, or signed when fix is high
module m_div_core
  import m_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;

  logic [XLEN-1:0] dividend_mag;
  logic [XLEN-1:0] divisor_mag;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  assign dividend_mag = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign divisor_mag  = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

  // Shift the next dividend bit (held in the quotient register MSB) into the
  // partial remainder; a borrow in diff means the trial subtract failed.
  assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvs_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (load) begin
      quo_reg   <= dividend_mag;
      rem_reg   <= '0;
      dvs_reg   <= divisor_mag;
      neg_q_reg <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r_reg <= is_signed & dividend[XLEN-1];
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_reg <= diff[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg <= rem_shift[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
      end
    end
  end

  // Quotient is negative when operand signs differ; remainder follows the
  // dividend's sign.
  assign quotient  = (fix && neg_q_reg) ? -quo_reg : quo_reg;
  assign remainder = (fix && neg_r_reg) ? -rem_reg : rem_reg;

endmodule

// File: rtl/m_unit_sequencer.sv
// m_unit_sequencer: multi-cycle RV32M sequencer in the execute stage.
// Accepts one M-extension op, stalls the front of the pipeline while it
// runs, then emits a single-cycle writeback pulse.
// Optional feature macro: M_UNIT_EARLY_OUT_EN (divide-by-zero, signed
// overflow and divide-by-one finish straight from accept).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             valid M-ext instruction in EX
//   func3             operation select
//   op1, op2          forwarded rs1 / rs2 values
//   rd_in             destination register
//   flush             pipeline flush, aborts any operation
//   stall             hold IF/ID/EX
//   done              one-cycle result-valid pulse
//   result            operation result (0 when done=0)
//   wb_rd             destination register (0 when done=0)
//   wb_reg_file       register-file write enable (equals done)
module m_unit_sequencer
  import m_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_file
);

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_reg, state_next;
  logic [2:0]        func3_reg;
  logic [XLEN-1:0]   op1_reg, op2_reg;
  logic [4:0]        rd_reg;
  logic [4:0]        count_reg;
  logic [2*XLEN-1:0] prod_reg;

  logic              accept;
  logic              early_out;
  logic              in_done;
  logic              a_signed, b_signed;
  logic [XLEN:0]     mul_a, mul_b;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   div_q, div_r;
  logic [XLEN-1:0]   quot_final, rem_final;
  logic              div_by_zero, div_overflow;
  logic [XLEN-1:0]   res_sel;

  assign accept  = start & ~flush & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));
  assign stall   = accept | (state_reg == ST_MUL) | (state_reg == ST_DIV);
  assign in_done = (state_reg == ST_DONE);

`ifdef M_UNIT_EARLY_OUT_EN
  // Decided on the live operands since the latched copies are not valid yet.
  assign early_out = is_div_op(func3) &
                     ((op2 == '0) |
                      (is_signed_div(func3) & (op1 == SIGNED_MIN) & (op2 == '1)) |
                      (op2 == {{(XLEN-1){1'b0}}, 1'b1}));
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (!start)                state_next = ST_IDLE;
          else if (!is_div_op(func3)) state_next = ST_MUL;
          else if (early_out)        state_next = ST_DONE;
          else                       state_next = ST_DIV;
        end
        ST_MUL:  state_next = ST_DONE;
        ST_DIV:  state_next = (count_reg == '0) ? ST_DONE : ST_DIV;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // 33-bit sign/zero-extended operands, widened to 64 bits so the modular
  // product equals the low 64 bits of the signed 66-bit product.
  assign a_signed = (func3_reg == F3_MULH) | (func3_reg == F3_MULHSU);
  assign b_signed = (func3_reg == F3_MULH);
  assign mul_a    = {a_signed & op1_reg[XLEN-1], op1_reg};
  assign mul_b    = {b_signed & op2_reg[XLEN-1], op2_reg};
  assign mul_prod = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      func3_reg <= '0;
      op1_reg   <= '0;
      op2_reg   <= '0;
      rd_reg    <= '0;
      count_reg <= '0;
      prod_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        func3_reg <= func3;
        op1_reg   <= op1;
        op2_reg   <= op2;
        rd_reg    <= rd_in;
        count_reg <= 5'(DIV_ITER - 1);
      end else if (state_reg == ST_DIV && count_reg != '0) begin
        count_reg <= count_reg - 5'd1;
      end
      if (state_reg == ST_MUL) begin
        prod_reg <= mul_prod;
      end
    end
  end

  m_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept & is_div_op(func3)),
    .step      (state_reg == ST_DIV),
    .fix       (in_done),
    .is_signed (is_signed_div(func3)),
    .dividend  (op1),
    .divisor   (op2),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Special cases override whatever the divider produced, so results are
  // the same whether or not the iterations were skipped.
  assign div_by_zero  = (op2_reg == '0);
  assign div_overflow = is_signed_div(func3_reg) & (op1_reg == SIGNED_MIN) & (op2_reg == '1);

  always_comb begin
    quot_final = div_q;
    rem_final  = div_r;
    if (div_by_zero) begin
      quot_final = '1;
      rem_final  = op1_reg;
    end else if (div_overflow) begin
      quot_final = SIGNED_MIN;
      rem_final  = '0;
    end
`ifdef M_UNIT_EARLY_OUT_EN
    else if (op2_reg == {{(XLEN-1){1'b0}}, 1'b1}) begin
      quot_final = op1_reg;
      rem_final  = '0;
    end
`endif
  end

  always_comb begin
    res_sel = '0;
    case (func3_reg)
      F3_MUL:                       res_sel = prod_reg[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_sel = prod_reg[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              res_sel = quot_final;
      F3_REM, F3_REMU:              res_sel = rem_final;
      default:                      res_sel = '0;
    endcase
  end

  // A flush arriving while the result is presented kills the writeback.
  assign done        = in_done & ~flush;
  assign wb_reg_file = done;
  assign wb_rd       = done ? rd_reg : 5'd0;
  assign result      = done ? res_sel : '0;

endmodule
